// File: rtl/spram_port_arbiter.sv
// Byte-wide read/write arbiter in front of a 16k x 16 single-port SPRAM.
// Optional write starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module spram_port_arbiter #(
  parameter int MAX_WR_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [14:0] rd_addr,
  output logic        rd_ack,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [3:0]  ram_maskwren,
  output logic        ram_wren,
  input  logic [15:0] ram_dout
);

  function automatic logic [7:0] lane_sel(input logic upper, input logic [15:0] word);
    return upper ? word[15:8] : word[7:0];
  endfunction

  logic force_wr;
  logic rd_gnt;
  logic wr_gnt;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] wr_wait_q, wr_wait_d;

  always_comb force_wr = wr_req && (wr_wait_q == 8'(MAX_WR_WAIT));

  always_comb begin
    wr_wait_d = wr_wait_q;
    if (!wr_req || wr_gnt)
      wr_wait_d = '0;
    else if (wr_wait_q < 8'(MAX_WR_WAIT))
      wr_wait_d = wr_wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_wait_q <= '0;
    else     wr_wait_q <= wr_wait_d;
  end
`else
  always_comb force_wr = 1'b0;
`endif

  // Reads win unless the guard forces a pending write through; reset masks both.
  always_comb begin
    rd_gnt = !rst && rd_req && !force_wr;
    wr_gnt = !rst && wr_req && (!rd_req || force_wr);
  end

  always_comb begin
    rd_ack       = rd_gnt;
    wr_ack       = wr_gnt;
    ram_addr     = '0;
    ram_din      = '0;
    ram_maskwren = '0;
    ram_wren     = 1'b0;
    if (wr_gnt) begin
      ram_addr     = wr_addr[14:1];
      ram_din      = {wr_data, wr_data};
      ram_maskwren = wr_addr[0] ? 4'b1100 : 4'b0011;
      ram_wren     = 1'b1;
    end else if (rd_gnt) begin
      ram_addr     = rd_addr[14:1];
    end
  end

  logic       vld_p1_q;
  logic       lane_p1_q;
  logic       vld_p2_q;
  logic [7:0] data_p2_q;

  // Stage p1: read issued, SPRAM output arrives next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      lane_p1_q <= 1'b0;
    end else begin
      vld_p1_q  <= rd_gnt;
      lane_p1_q <= rd_gnt ? rd_addr[0] : lane_p1_q;
    end
  end

  // Stage p2: byte lane selected and held until the next valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) data_p2_q <= lane_sel(lane_p1_q, ram_dout);
    end
  end

  assign rd_valid = vld_p2_q;
  assign rd_data  = data_p2_q;

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Bench for spram_port_arbiter: byte-level reference model, word-level SPRAM model,
// directed scenarios with literal expectations followed by randomized traffic.
module tb_spram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req = 1'b0;
  logic [14:0] rd_addr = '0;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_req = 1'b0;
  logic [14:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack;
  logic [13:0] ram_addr;
  logic [15:0] ram_din;
  logic [3:0]  ram_maskwren;
  logic        ram_wren;
  logic [15:0] ram_dout = '0;

  localparam int MAXW = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  spram_port_arbiter #(.MAX_WR_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_maskwren(ram_maskwren), .ram_wren(ram_wren),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial SPRAM contents shared by the RAM model and the reference model.
  function automatic logic [15:0] word_init(input int w);
    logic [15:0] v;
    v = 16'(w * 40503) ^ 16'h5A5A;
    if (w < 8) v = {8'(8'hA0 + 2 * w + 1), 8'(8'hA0 + 2 * w)};
    if (w == 16'h0010) v = 16'hBEEF;
    return v;
  endfunction

  // SPRAM model: registered read, nibble write masks.
  logic [15:0] ram_mem [0:16383];
  initial begin
    logic [15:0] nw;
    for (int w = 0; w < 16384; w++) ram_mem[w] = word_init(w);
    forever begin
      @(posedge clk);
      if (ram_wren) begin
        nw = ram_mem[ram_addr];
        for (int n = 0; n < 4; n++)
          if (ram_maskwren[n]) nw[n*4 +: 4] = ram_din[n*4 +: 4];
        ram_mem[ram_addr] = nw;
      end else begin
        ram_dout <= ram_mem[ram_addr];
      end
    end
  end

  // Reference model: byte-addressed memory, queue of pending read results.
  typedef struct { int due; logic [7:0] b; } rexp_t;
  logic [7:0] bmem [0:32767];
  initial begin
    rexp_t rq[$];
    rexp_t e;
    int ncyc;
    int wwait;
    logic [7:0] held;
    logic fw, erd, ewr, ev;
    logic [15:0] wv;
    for (int w = 0; w < 16384; w++) begin
      wv = word_init(w);
      bmem[2*w]   = wv[7:0];
      bmem[2*w+1] = wv[15:8];
    end
    ncyc = 0; wwait = 0; held = 8'h00;
    forever begin
      @(negedge clk);
      ncyc++;
      fw  = GUARD && wr_req && (wwait == MAXW);
      erd = !rst && rd_req && !fw;
      ewr = !rst && wr_req && (!rd_req || fw);
      chk("rd_ack", 32'(rd_ack), 32'(erd));
      chk("wr_ack", 32'(wr_ack), 32'(ewr));
      if (ewr) begin
        chk("wr_bus", {ram_wren, 3'b0, ram_maskwren, ram_addr, 2'b0, 8'h0},
            {1'b1, 3'b0, (wr_addr[0] ? 4'b1100 : 4'b0011), wr_addr[14:1], 2'b0, 8'h0});
        chk("wr_din", 32'(ram_din), 32'({wr_data, wr_data}));
      end else if (erd) begin
        chk("rd_bus", {ram_wren, 17'h0, ram_addr}, {1'b0, 17'h0, rd_addr[14:1]});
      end else begin
        chk("idle_bus", {ram_wren, ram_maskwren, ram_addr, 13'h0}, 32'h0);
        chk("idle_din", 32'(ram_din), 32'h0);
      end
      if (rst) begin
        rq.delete();
        held = 8'h00;
        wwait = 0;
      end else begin
        ev = (rq.size() > 0) && (rq[0].due == ncyc);
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        if (ev) begin
          held = rq[0].b;
          void'(rq.pop_front());
        end
        chk("rd_data", 32'(rd_data), 32'(held));
        if (ewr) bmem[wr_addr] = wr_data;
        if (erd) begin
          e.due = ncyc + 2;
          e.b = bmem[rd_addr];
          rq.push_back(e);
        end
        if (!wr_req || ewr) wwait = 0;
        else if (wwait < MAXW) wwait++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [14:0] a, input logic [7:0] exp);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    chk("dir_rd_ack", 32'(rd_ack), 32'd1);
    chk("dir_rd_addr", 32'(ram_addr), 32'(a >> 1));
    step();
    rd_req = 1'b0;
    step();
    @(negedge clk);
    chk("dir_rd_valid", 32'(rd_valid), 32'd1);
    chk("dir_rd_data", 32'(rd_data), 32'(exp));
    step();
  endtask

  task automatic do_write(input logic [14:0] a, input logic [7:0] d,
                          input logic [3:0] m, input logic [15:0] din);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    chk("dir_wr_ack", 32'(wr_ack), 32'd1);
    chk("dir_wr_mask", 32'(ram_maskwren), 32'(m));
    chk("dir_wr_din", 32'(ram_din), 32'(din));
    step();
    wr_req = 1'b0;
  endtask

  initial begin
    logic rdh, wrh;
    // Reset with a read pending: ack must stay low.
    rst = 1'b1; rd_req = 1'b1; rd_addr = 15'h0021;
    @(negedge clk);
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    step(); step();
    rst = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    step();

    do_read(15'h0021, 8'hBE);
    do_read(15'h0020, 8'hEF);

    do_write(15'h0040, 8'h34, 4'b0011, 16'h3434);
    do_write(15'h0041, 8'h12, 4'b1100, 16'h1212);
    do_read(15'h0040, 8'h34);
    do_read(15'h0041, 8'h12);

    // Contention: reads win while rd_req is high.
    rd_req = 1'b1; rd_addr = 15'h0002; wr_req = 1'b1; wr_addr = 15'h0051; wr_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cont_rd_ack", 32'(rd_ack), 32'd1);
      chk("cont_wr_ack", 32'(wr_ack), 32'd0);
      step();
    end
    rd_req = 1'b0;
    @(negedge clk);
    chk("cont_wr_late", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0;
    step(); step();

    // Reset the cycle after a read ack: the read is dropped.
    rd_req = 1'b1; rd_addr = 15'h0021;
    @(negedge clk);
    chk("mid_rd_ack", 32'(rd_ack), 32'd1);
    step();
    rd_req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_valid", 32'(rd_valid), 32'd0);
    chk("mid_data0", 32'(rd_data), 32'd0);
    step();
    @(negedge clk);
    chk("mid_no_valid2", 32'(rd_valid), 32'd0);
    step();
    do_read(15'h0021, 8'hBE);

    // 16 back-to-back reads over the 0xA0.. byte pattern.
    for (int i = 0; i < 18; i++) begin
      rd_req = (i < 16); rd_addr = 15'(i < 16 ? i : 0);
      @(negedge clk);
      if (i < 16) chk("pipe_ack", 32'(rd_ack), 32'd1);
      chk("pipe_valid", 32'(rd_valid), 32'(i >= 2));
      if (i >= 2) chk("pipe_data", 32'(rd_data), 32'(8'hA0 + i - 2));
      step();
    end
    rd_req = 1'b0;
    step();

`ifdef ARB_STARVE_GUARD_EN
    // Continuous reads with a pending write: write forced through on the 5th cycle.
    rd_req = 1'b1; rd_addr = 15'h0003; wr_req = 1'b1; wr_addr = 15'h0060; wr_data = 8'h5C;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("guard_wr_ack", 32'(wr_ack), 32'(i == 4));
      chk("guard_rd_ack", 32'(rd_ack), 32'(i != 4));
      step();
      if (i == 4) wr_req = 1'b0;
    end
    rd_req = 1'b0;
    step(); step();
`endif

    // Randomized traffic; requests are held until acked.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rdh = rd_req && !rd_ack;
      wrh = wr_req && !wr_ack;
      @(posedge clk);
      #1;
      if (!rdh) begin
        rd_req = ($urandom_range(0, 2) != 0);
        rd_addr = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 127));
      end
      if (!wrh) begin
        wr_req = ($urandom_range(0, 1) != 0);
        wr_addr = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 127));
        wr_data = 8'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
